btn_debouncer: RTL and testbench
================================

# btn_debouncer

Parametrised multi-channel input conditioner for the ULX3S push buttons and other slow mechanical inputs. Each channel is synchronised into `clk`, debounced with its own counter-based state machine, and given clean level, rising-edge and falling-edge outputs. Optional long-press detection is included. It sits between the board pins and the SoC or reset logic in the FPGA top, replacing raw `btn` usage.

## Interface
- `NUM_CH`, 7: number of independent channels.
- `CLK_FREQ`, 25_000_000: `clk` frequency in Hz.
- `DEBOUNCE_US`, 10_000: required stable time in µs.
  - DEBOUNCE_CYCLES = CLK_FREQ/1_000_000*DEBOUNCE_US.
  - Must be ≥ 1; elaboration error otherwise.
- `SYNC_STAGES`, 2: synchroniser depth; must be ≥ 2.
- `INVERT_MASK`, '0 (NUM_CH bits): bit i set means channel i is active-low at the pin and is inverted before synchronisation.
- `LONGPRESS_US`, 1_000_000: hold time in µs for a long-press event.
  - LONGPRESS_CYCLES = CLK_FREQ/1_000_000*LONGPRESS_US.
  - Only used with the long-press macro.

Ports:
- `clk` input 1: system clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `btn_i` input NUM_CH: raw asynchronous pin inputs.
- `level_o` output NUM_CH: debounced logical level (1 = pressed).
- `rise_o` output NUM_CH: one-cycle pulse on debounced 0→1.
- `fall_o` output NUM_CH: one-cycle pulse on debounced 1→0.
- `long_o` output NUM_CH: one-cycle pulse when a press has been held for LONGPRESS_CYCLES.

## Operation
- Per channel: optional inversion, then a SYNC_STAGES flop chain producing `s`, then a 4-state FSM with counter `cnt`.
  - `cnt` width is $clog2(DEBOUNCE_CYCLES+1).
- STABLE_LO:
  - `level_o`=0.
  - `s`=1 → PEND_HI, `cnt`←0.
- PEND_HI:
  - `s`=0 → STABLE_LO (bounce rejected, no pulse).
  - `s`=1 and `cnt`==DEBOUNCE_CYCLES-1 → STABLE_HI, `rise_o` pulses, `level_o`←1.
  - Otherwise `cnt`++.
- STABLE_HI and PEND_LO behave symmetrically. Leaving PEND_LO to STABLE_LO pulses `fall_o`.
- A bounce on the final counting cycle still rejects the transition; the counter restarts on the next qualifying edge.
- Channels are fully independent. Simultaneous events on several channels all produce their pulses in the same cycle.
- `rise_o`, `fall_o` and `long_o` are never asserted for more than one cycle per event.

## Timing
- Reset values:
  - All sync flops 0, so a channel reads as logical not-pressed.
  - FSM in STABLE_LO, `cnt`=0.
  - `level_o`, `rise_o`, `fall_o` and `long_o` all 0.
- Reset asserted mid-PEND aborts the pending transition with no pulse.
- A button held across reset release produces `rise_o` after the normal latency.
- Latency: a clean pin change sampled at edge k gives a pulse, with `level_o` updated, at edge k+SYNC_STAGES+DEBOUNCE_CYCLES. All outputs are registered.
- `level_o` changes in the same cycle as its `rise_o` or `fall_o` pulse.

## Configuration
- `BTN_LONGPRESS_EN` defined:
  - Each channel has a hold counter that clears on entering STABLE_HI and increments while in STABLE_HI or PEND_LO.
  - When the count reaches LONGPRESS_CYCLES, measured from the `rise_o` cycle, `long_o` pulses once.
  - The counter then saturates, so there is no repeat until the next press.
  - Release before that point gives no `long_o`.
- Not defined: the hold counters are not generated and `long_o` is tied to 0. The port list is unchanged.

## Structure
- Package `btn_pkg`:
  - `btn_state_e` enum (STABLE_LO, PEND_HI, STABLE_HI, PEND_LO).
  - Function computing cycle counts from Hz/µs.
  - Shared width helper.
- Sub-module `btn_debounce_ch`: one channel containing synchroniser, FSM, counter and optional hold counter. The top generates NUM_CH instances and applies INVERT_MASK.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, DEBOUNCE_US=8, LONGPRESS_US=32, NUM_CH=3, INVERT_MASK=3'b100.

1. Clean press: `btn_i[0]` 0→1 at edge k → `rise_o[0]` high only at edge k+10, `level_o[0]`=1 from then. Release → `fall_o[0]` at release edge +10.
2. Bounce: `btn_i[1]` toggles 1 for 7 cycles, 0 for 1 cycle, then holds 1 → no pulse during the bounce; `rise_o[1]` at 10 cycles after the final rising sample.
3. Inverted channel: `btn_i[2]`=1 from reset → `level_o[2]` stays 0. Drive 0 → `rise_o[2]` after 10 cycles.
4. Simultaneous: channels 0 and 1 pressed on the same edge → both `rise_o` bits high in the same single cycle.
5. Reset mid-pend: assert `reset_n`=0 5 cycles into PEND_HI → all outputs 0 immediately, no `rise_o`. A held input after release gives `rise_o` 10 cycles later.
6. Long press (`BTN_LONGPRESS_EN`): hold 100 cycles → exactly one `long_o[0]` pulse, 32 cycles after `rise_o[0]`. Hold 20 cycles → no `long_o`. Without the macro, `long_o` stays 0 throughout.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer: FSM state encoding,
// Hz/us to cycle conversion and counter width sizing.
package btn_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } btn_state_e;

  function automatic int us_to_cycles(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  // Width able to hold 0..n inclusive, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// Pin-side and event-side signals of the debouncer, plus per-channel FSM state
// (2 bits per channel, btn_state_e encoding) for observation.
interface btn_debouncer_if #(
  parameter int NUM_CH = 7
);
  logic [NUM_CH-1:0]   btn_i;
  logic [NUM_CH-1:0]   level_o;
  logic [NUM_CH-1:0]   rise_o;
  logic [NUM_CH-1:0]   fall_o;
  logic [NUM_CH-1:0]   long_o;
  logic [2*NUM_CH-1:0] dbg_state;

  // No handshake: btn_i is a free-running level; rise_o/fall_o/long_o are
  // single-cycle event strobes with no ready, consumers must sample every cycle.
  modport master (
    output btn_i,
    input  level_o, rise_o, fall_o, long_o, dbg_state
  );

  modport slave (
    input  btn_i,
    output level_o, rise_o, fall_o, long_o, dbg_state
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One debounced channel: synchroniser, 4-state stable/pending FSM with counter,
// and (with BTN_LONGPRESS_EN defined) a saturating long-press hold counter.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
`ifdef BTN_LONGPRESS_EN
  , parameter int LONGPRESS_CYCLES = 1
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pin,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       long_press,
  output logic [1:0] state_dbg
);

  localparam int                CNT_W       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]        S_STABLE_LO = STABLE_LO;
  localparam logic [1:0]        S_PEND_HI   = PEND_HI;
  localparam logic [1:0]        S_STABLE_HI = STABLE_HI;
  localparam logic [1:0]        S_PEND_LO   = PEND_LO;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], pin};
  end

  assign s         = sync[SYNC_STAGES-1];
  assign state_dbg = state;

  // A disagreeing sample during PEND_* drops straight back to the stable state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        S_STABLE_LO: if (s) begin
          state <= S_PEND_HI;
          cnt   <= '0;
        end
        S_PEND_HI: begin
          if (!s) state <= S_STABLE_LO;
          else if (cnt == CNT_LAST) begin
            state <= S_STABLE_HI;
            level <= 1'b1;
            rise  <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        end
        S_STABLE_HI: if (!s) begin
          state <= S_PEND_LO;
          cnt   <= '0;
        end
        S_PEND_LO: begin
          if (s) state <= S_STABLE_HI;
          else if (cnt == CNT_LAST) begin
            state <= S_STABLE_LO;
            level <= 1'b0;
            fall  <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        end
        default: state <= S_STABLE_LO;
      endcase
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int               HOLD_W   = cnt_width(LONGPRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONGPRESS_CYCLES);

  logic [HOLD_W-1:0] hold;

  // Cleared only on the rise commit so a PEND_LO bounce keeps timing the press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (state == S_PEND_HI && s && cnt == CNT_LAST) begin
        hold <= '0;
      end else if ((state == S_STABLE_HI || state == S_PEND_LO) && hold != HOLD_MAX) begin
        hold <= hold + HOLD_W'(1);
        if (hold == HOLD_MAX - HOLD_W'(1)) long_press <= 1'b1;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/btn_debouncer.sv
// Multi-channel push-button conditioner: per-channel inversion, sync and debounce.
// Long-press detection is built only when BTN_LONGPRESS_EN is defined.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int                NUM_CH       = 7,
  parameter int                CLK_FREQ     = 25_000_000,
  parameter int                DEBOUNCE_US  = 10_000,
  parameter int                SYNC_STAGES  = 2,
  parameter logic [NUM_CH-1:0] INVERT_MASK  = '0,
  parameter int                LONGPRESS_US = 1_000_000
) (
  input  logic            clk,
  input  logic            reset_n,
  btn_debouncer_if.slave  bus
);

  localparam int DEBOUNCE_CYCLES  = us_to_cycles(CLK_FREQ, DEBOUNCE_US);
  localparam int LONGPRESS_CYCLES = us_to_cycles(CLK_FREQ, LONGPRESS_US);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("btn_debouncer: SYNC_STAGES must be >= 2");
  end
  if (LONGPRESS_CYCLES < 1) begin : g_bad_longpress
    $error("btn_debouncer: LONGPRESS_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_LONGPRESS_EN
      , .LONGPRESS_CYCLES(LONGPRESS_CYCLES)
`endif
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin        (bus.btn_i[i] ^ INVERT_MASK[i]),
      .level      (bus.level_o[i]),
      .rise       (bus.rise_o[i]),
      .fall       (bus.fall_o[i]),
      .long_press (bus.long_o[i]),
      .state_dbg  (bus.dbg_state[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer: per-cycle comparison against a sample-history
// model plus hand-computed latency checks on recorded event cycles.
module tb_btn_debouncer;

  localparam int             NUM_CH  = 3;
  localparam int             SYNC    = 2;
  localparam int             DEB     = 8;
  localparam int             LP      = 32;
  localparam logic [NUM_CH-1:0] INV  = 3'b100;
  localparam int             LAT     = SYNC + DEB;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_vec;
  int   n_err;

  btn_debouncer_if #(.NUM_CH(NUM_CH)) bus ();

  btn_debouncer #(
    .NUM_CH       (NUM_CH),
    .CLK_FREQ     (1_000_000),
    .DEBOUNCE_US  (DEB),
    .SYNC_STAGES  (SYNC),
    .INVERT_MASK  (INV),
    .LONGPRESS_US (LP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model ----------------
  // A change is accepted once DEB+1 consecutive pin samples, seen SYNC cycles
  // late, disagree with the current level.
  logic [NUM_CH-1:0] m_level, m_rise, m_fall, m_long;
  int                m_run  [NUM_CH];
  int                m_hold [NUM_CH];
  logic [NUM_CH-1:0] pin_hist[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_level = '0; m_rise = '0; m_fall = '0; m_long = '0;
      pin_hist = {};
      for (int i = 0; i < SYNC; i++) pin_hist.push_back('0);
      for (int c = 0; c < NUM_CH; c++) begin
        m_run[c]  = 0;
        m_hold[c] = 0;
      end
    end else begin
      logic [NUM_CH-1:0] seen;
      pin_hist.push_back(bus.btn_i ^ INV);
      seen = pin_hist.pop_front();
      m_rise = '0; m_fall = '0; m_long = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_level[c] && m_hold[c] < LP) begin
          m_hold[c]++;
`ifdef BTN_LONGPRESS_EN
          if (m_hold[c] == LP) m_long[c] = 1'b1;
`endif
        end
        if (seen[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB + 1) begin
            m_run[c]   = 0;
            m_level[c] = seen[c];
            if (seen[c]) begin
              m_rise[c] = 1'b1;
              m_hold[c] = 0;
            end else m_fall[c] = 1'b1;
          end
        end else m_run[c] = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  int rise_cnt [NUM_CH];
  int fall_cnt [NUM_CH];
  int long_cnt [NUM_CH];
  int rise_at  [NUM_CH];
  int fall_at  [NUM_CH];
  int long_at  [NUM_CH];

  always @(negedge clk) begin
    cmp("level_o", 32'(bus.level_o), 32'(m_level));
    cmp("rise_o",  32'(bus.rise_o),  32'(m_rise));
    cmp("fall_o",  32'(bus.fall_o),  32'(m_fall));
    cmp("long_o",  32'(bus.long_o),  32'(m_long));
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.rise_o[c]) begin rise_cnt[c]++; rise_at[c] = cyc; end
      if (bus.fall_o[c]) begin fall_cnt[c]++; fall_at[c] = cyc; end
      if (bus.long_o[c]) begin long_cnt[c]++; long_at[c] = cyc; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives pin ch after a falling edge; returns the rising edge that samples it.
  task automatic set_pin(input int ch, input logic v, output int edge_k);
    @(negedge clk);
    bus.btn_i[ch] = v;
    edge_k = cyc + 1;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, " level"}, 32'(bus.level_o), 32'd0);
    cmp({tag, " rise"},  32'(bus.rise_o),  32'd0);
    cmp({tag, " fall"},  32'(bus.fall_o),  32'd0);
    cmp({tag, " long"},  32'(bus.long_o),  32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, k2, kf, rc0, rc1, lc0;
    cyc = 0; n_vec = 0; n_err = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; long_cnt[c] = 0;
      rise_at[c] = 0; fall_at[c] = 0; long_at[c] = 0;
    end
    bus.btn_i = 3'b100;
    reset_n   = 1'b0;
    #1;
    check_all_zero("reset");
    wait_cycles(3);
    #2 reset_n = 1'b1;
    wait_cycles(5);

    // 1: clean press and release on ch0
    set_pin(0, 1'b1, k);
    wait_cycles(15);
    cmp("t1 rise count", 32'(rise_cnt[0]), 32'd1);
    cmp("t1 rise latency", 32'(rise_at[0] - k), 32'(LAT));
    cmp("t1 level held", 32'(bus.level_o[0]), 32'd1);
    set_pin(0, 1'b0, k);
    wait_cycles(15);
    cmp("t1 fall count", 32'(fall_cnt[0]), 32'd1);
    cmp("t1 fall latency", 32'(fall_at[0] - k), 32'(LAT));

    // 2: bounce on ch1: 7 high, 1 low, then hold high
    set_pin(1, 1'b1, k);
    wait_cycles(6);
    set_pin(1, 1'b0, k2);
    set_pin(1, 1'b1, kf);
    cmp("t2 no rise in bounce", 32'(rise_cnt[1]), 32'd0);
    wait_cycles(15);
    cmp("t2 rise count", 32'(rise_cnt[1]), 32'd1);
    cmp("t2 rise latency", 32'(rise_at[1] - kf), 32'(LAT));
    set_pin(1, 1'b0, k);
    wait_cycles(15);

    // 3: inverted ch2, pin high since reset reads not-pressed
    cmp("t3 idle level", 32'(rise_cnt[2]), 32'd0);
    set_pin(2, 1'b0, k);
    wait_cycles(15);
    cmp("t3 rise latency", 32'(rise_at[2] - k), 32'(LAT));
    cmp("t3 level", 32'(bus.level_o[2]), 32'd1);
    set_pin(2, 1'b1, k);
    wait_cycles(15);
    cmp("t3 fall count", 32'(fall_cnt[2]), 32'd1);

    // 4: simultaneous press on ch0 and ch1
    rc0 = rise_cnt[0]; rc1 = rise_cnt[1];
    @(negedge clk);
    bus.btn_i[1:0] = 2'b11;
    k = cyc + 1;
    wait_cycles(15);
    cmp("t4 ch0 rise latency", 32'(rise_at[0] - k), 32'(LAT));
    cmp("t4 ch1 rise latency", 32'(rise_at[1] - k), 32'(LAT));
    cmp("t4 ch0 single pulse", 32'(rise_cnt[0] - rc0), 32'd1);
    cmp("t4 ch1 single pulse", 32'(rise_cnt[1] - rc1), 32'd1);
    @(negedge clk);
    bus.btn_i[1:0] = 2'b00;
    wait_cycles(15);

    // 5: reset five cycles into PEND_HI, button held through release
    rc0 = rise_cnt[0];
    set_pin(0, 1'b1, k);
    wait_cycles(6);
    #2 reset_n = 1'b0;
    #1 check_all_zero("t5 in reset");
    wait_cycles(3);
    #2 reset_n = 1'b1;
    k = cyc + 1;
    cmp("t5 no rise aborted", 32'(rise_cnt[0] - rc0), 32'd0);
    wait_cycles(15);
    cmp("t5 rise count", 32'(rise_cnt[0] - rc0), 32'd1);
    cmp("t5 rise latency", 32'(rise_at[0] - k), 32'(LAT));
    set_pin(0, 1'b0, k);
    wait_cycles(15);

    // 6: long hold then short hold on ch0
    lc0 = long_cnt[0];
    set_pin(0, 1'b1, k);
    wait_cycles(99);
    set_pin(0, 1'b0, k);
    wait_cycles(15);
`ifdef BTN_LONGPRESS_EN
    cmp("t6 long count", 32'(long_cnt[0] - lc0), 32'd1);
    cmp("t6 long delay", 32'(long_at[0] - rise_at[0]), 32'(LP));
`else
    cmp("t6 long disabled", 32'(long_cnt[0] - lc0), 32'd0);
`endif
    lc0 = long_cnt[0];
    set_pin(0, 1'b1, k);
    wait_cycles(19);
    set_pin(0, 1'b0, k);
    wait_cycles(15);
    cmp("t6 short no long", 32'(long_cnt[0] - lc0), 32'd0);
    cmp("t6 short fall latency", 32'(fall_at[0] - k), 32'(LAT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
